// File: rtl/ex_mem_if.sv
// EX/MEM pipeline bus: execute-stage inputs and the memory-stage and forwarding outputs.
// The master drives the ex_* side; the slave (the pipeline register) drives mem_* and forward_*.
interface ex_mem_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic [XLEN-1:0] ex_alu_result;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_store_data;
  logic [4:0]      ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic [1:0]      ex_mem_size;
  logic            ex_is_link;

  logic            mem_valid;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_store_data;
  logic [4:0]      mem_rd;
  logic            mem_reg_write;
  logic            mem_mem_read;
  logic            mem_mem_write;
  logic [1:0]      mem_mem_size;
  logic            mem_misaligned;
  logic [XLEN-1:0] forward_ex_mem;
  logic [4:0]      forward_ex_mem_rd;
  logic            forward_ex_mem_en;

  modport master (
    output ex_valid, ex_alu_result, ex_pc, ex_store_data, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_size, ex_is_link,
    input  mem_valid, mem_addr, mem_store_data, mem_rd, mem_reg_write, mem_mem_read,
           mem_mem_write, mem_mem_size, mem_misaligned, forward_ex_mem,
           forward_ex_mem_rd, forward_ex_mem_en
  );

  modport slave (
    input  ex_valid, ex_alu_result, ex_pc, ex_store_data, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_size, ex_is_link,
    output mem_valid, mem_addr, mem_store_data, mem_rd, mem_reg_write, mem_mem_read,
           mem_mem_write, mem_mem_size, mem_misaligned, forward_ex_mem,
           forward_ex_mem_rd, forward_ex_mem_en
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush, load/store alignment check and EX forwarding.
// Optional feature macro: EX_MEM_LINK_FWD_EN (forward PC+4 for JAL/JALR instead of the ALU result).
module ex_mem_reg #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     stall,
  input  logic     flush,
  ex_mem_if.slave  bus
);

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic m;
    m = 1'b0;
    case (size)
      2'b01:   m = addr_lo[0];
      2'b10:   m = (addr_lo != 2'b00);
      2'b11:   m = 1'b1;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  logic            rd_eff_p0;
  logic            mis_p0;
  logic            mis_q_p0;
  logic            rd_q_p0;
  logic            wr_q_p0;
  logic            rw_q_p0;
  logic            fwd_en_p0;
  logic [XLEN-1:0] fwd_val_p0;

  always_comb begin
    // Both strobes set is treated as a store, so the read is dropped up front.
    rd_eff_p0  = bus.ex_mem_read & ~bus.ex_mem_write;
    mis_p0     = (bus.ex_mem_read | bus.ex_mem_write) &
                 misaligned(bus.ex_mem_size, bus.ex_alu_result[1:0]);
    mis_q_p0   = bus.ex_valid & mis_p0;
    rd_q_p0    = bus.ex_valid & rd_eff_p0 & ~mis_p0;
    wr_q_p0    = bus.ex_valid & bus.ex_mem_write & ~mis_p0;
    rw_q_p0    = bus.ex_valid & bus.ex_reg_write & (bus.ex_rd != 5'd0) & ~(rd_eff_p0 & mis_p0);
    fwd_en_p0  = rw_q_p0 & ~rd_eff_p0;
`ifdef EX_MEM_LINK_FWD_EN
    fwd_val_p0 = bus.ex_is_link ? (bus.ex_pc + XLEN'(4)) : bus.ex_alu_result;
`else
    fwd_val_p0 = bus.ex_alu_result;
`endif
  end

`ifndef EX_MEM_LINK_FWD_EN
  logic unused_link_p0;
  assign unused_link_p0 = ^{bus.ex_pc, bus.ex_is_link};
`endif

  logic            vld_p1;
  logic [XLEN-1:0] addr_p1;
  logic [XLEN-1:0] store_data_p1;
  logic [4:0]      rd_p1;
  logic            rw_p1;
  logic            mrd_p1;
  logic            mwr_p1;
  logic [1:0]      size_p1;
  logic            mis_p1;
  logic [XLEN-1:0] fwd_val_p1;
  logic            fwd_en_p1;

  // ---- p0 -> p1 boundary: rst > flush > stall > load ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1        <= 1'b0;
      addr_p1       <= '0;
      store_data_p1 <= '0;
      rd_p1         <= 5'd0;
      rw_p1         <= 1'b0;
      mrd_p1        <= 1'b0;
      mwr_p1        <= 1'b0;
      size_p1       <= 2'b00;
      mis_p1        <= 1'b0;
      fwd_val_p1    <= '0;
      fwd_en_p1     <= 1'b0;
    end else if (flush) begin
      vld_p1    <= 1'b0;
      rw_p1     <= 1'b0;
      mrd_p1    <= 1'b0;
      mwr_p1    <= 1'b0;
      mis_p1    <= 1'b0;
      fwd_en_p1 <= 1'b0;
    end else if (!stall) begin
      vld_p1        <= bus.ex_valid;
      addr_p1       <= bus.ex_alu_result;
      store_data_p1 <= bus.ex_store_data;
      rd_p1         <= bus.ex_rd;
      rw_p1         <= rw_q_p0;
      mrd_p1        <= rd_q_p0;
      mwr_p1        <= wr_q_p0;
      size_p1       <= bus.ex_mem_size;
      mis_p1        <= mis_q_p0;
      fwd_val_p1    <= fwd_val_p0;
      fwd_en_p1     <= fwd_en_p0;
    end
  end

  assign bus.mem_valid         = vld_p1;
  assign bus.mem_addr          = addr_p1;
  assign bus.mem_store_data    = store_data_p1;
  assign bus.mem_rd            = rd_p1;
  assign bus.mem_reg_write     = rw_p1;
  assign bus.mem_mem_read      = mrd_p1;
  assign bus.mem_mem_write     = mwr_p1;
  assign bus.mem_mem_size      = size_p1;
  assign bus.mem_misaligned    = mis_p1;
  assign bus.forward_ex_mem    = fwd_val_p1;
  assign bus.forward_ex_mem_rd = rd_p1;
  assign bus.forward_ex_mem_en = fwd_en_p1;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed self-checking bench for ex_mem_reg; link-forward expectations follow EX_MEM_LINK_FWD_EN.
module tb_ex_mem_reg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   failures = 0;

  ex_mem_if #(.XLEN(32)) bus ();

  ex_mem_reg #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [113:0] all_outs();
    return {bus.mem_valid, bus.mem_addr, bus.mem_store_data, bus.mem_rd, bus.mem_reg_write,
            bus.mem_mem_read, bus.mem_mem_write, bus.mem_mem_size, bus.mem_misaligned,
            bus.forward_ex_mem, bus.forward_ex_mem_rd, bus.forward_ex_mem_en};
  endfunction

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] pc,
                       input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic mw, input logic [1:0] sz, input logic lk);
    bus.ex_valid      = v;
    bus.ex_alu_result = alu;
    bus.ex_pc         = pc;
    bus.ex_store_data = sd;
    bus.ex_rd         = rd;
    bus.ex_reg_write  = rw;
    bus.ex_mem_read   = mr;
    bus.ex_mem_write  = mw;
    bus.ex_mem_size   = sz;
    bus.ex_is_link    = lk;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 32'hDEAD_BEEF, 32'h40, 32'h77, 5'd9, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    #1 rst = 1'b1;
    #2;
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("FAIL reset_initial outs=%h required=0", all_outs());
    end
    #9 rst = 1'b0;
    drive(1'b1, 32'h1234, 32'h100, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    step();
    checks++;
    if ({bus.forward_ex_mem, bus.forward_ex_mem_rd, bus.forward_ex_mem_en} !== {32'h1234, 5'd5, 1'b1}) begin
      failures++;
      $display("FAIL add_fwd got=%h/%0d/%b required=1234/5/1",
               bus.forward_ex_mem, bus.forward_ex_mem_rd, bus.forward_ex_mem_en);
    end
    checks++;
    if ({bus.mem_valid, bus.mem_reg_write, bus.mem_mem_size} !== {1'b1, 1'b1, 2'b10}) begin
      failures++;
      $display("FAIL add_ctrl got valid=%b rw=%b size=%b required 1 1 10",
               bus.mem_valid, bus.mem_reg_write, bus.mem_mem_size);
    end
    // Mid-cycle asynchronous reset with non-zero inputs and mid-stall.
    stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("FAIL reset_async outs=%h required=0", all_outs());
    end
    step();
    #2 rst = 1'b0;
    stall = 1'b0;
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("FAIL reset_hold outs=%h required=0", all_outs());
    end
    step();
    checks++;
    if ({bus.mem_valid, bus.mem_addr} !== {1'b1, 32'h1234}) begin
      failures++;
      $display("FAIL first_capture got valid=%b addr=%h required 1 00001234", bus.mem_valid, bus.mem_addr);
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 32'hA, 32'h200, 32'hCAFE, 5'd3, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    step();
    checks++;
    if ({bus.forward_ex_mem, bus.forward_ex_mem_rd} !== {32'hA, 5'd3}) begin
      failures++;
      $display("FAIL load_a got=%h/%0d required=a/3", bus.forward_ex_mem, bus.forward_ex_mem_rd);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h55 + i, 32'h300, 32'h99, 5'd9 + 5'(i), 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
      step();
      checks++;
      if ({bus.forward_ex_mem, bus.forward_ex_mem_rd, bus.mem_store_data, bus.forward_ex_mem_en, bus.mem_mem_read}
          !== {32'hA, 5'd3, 32'hCAFE, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold_%0d got fwd=%h rd=%0d sd=%h en=%b rd=%b required a 3 cafe 1 0",
                 i, bus.forward_ex_mem, bus.forward_ex_mem_rd, bus.mem_store_data,
                 bus.forward_ex_mem_en, bus.mem_mem_read);
      end
    end
    flush = 1'b1;
    step();
    checks++;
    if ({bus.mem_valid, bus.forward_ex_mem_en, bus.mem_reg_write, bus.mem_mem_read} !== 4'b0000) begin
      failures++;
      $display("FAIL stall_flush got valid=%b en=%b rw=%b rd=%b required 0 0 0 0",
               bus.mem_valid, bus.forward_ex_mem_en, bus.mem_reg_write, bus.mem_mem_read);
    end
    checks++;
    if (bus.mem_addr !== 32'hA) begin
      failures++;
      $display("FAIL flush_data_held got=%h required=a", bus.mem_addr);
    end
    flush = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_alignment();
    drive(1'b1, 32'h1002, 32'h0, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    step();
    checks++;
    if ({bus.mem_misaligned, bus.mem_mem_read, bus.mem_reg_write, bus.forward_ex_mem_en} !== 4'b1000) begin
      failures++;
      $display("FAIL lw_misaligned got mis=%b rd=%b rw=%b en=%b required 1 0 0 0",
               bus.mem_misaligned, bus.mem_mem_read, bus.mem_reg_write, bus.forward_ex_mem_en);
    end
    drive(1'b1, 32'h1002, 32'h0, 32'h1111, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    step();
    checks++;
    if ({bus.mem_mem_write, bus.mem_misaligned, bus.mem_mem_size} !== {1'b1, 1'b0, 2'b01}) begin
      failures++;
      $display("FAIL sh_aligned got wr=%b mis=%b size=%b required 1 0 01",
               bus.mem_mem_write, bus.mem_misaligned, bus.mem_mem_size);
    end
    drive(1'b1, 32'h1003, 32'h0, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    step();
    checks++;
    if ({bus.mem_misaligned, bus.mem_mem_read, bus.mem_reg_write} !== 3'b011) begin
      failures++;
      $display("FAIL lb_odd got mis=%b rd=%b rw=%b required 0 1 1",
               bus.mem_misaligned, bus.mem_mem_read, bus.mem_reg_write);
    end
    drive(1'b1, 32'h1000, 32'h0, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
    step();
    checks++;
    if ({bus.mem_misaligned, bus.mem_mem_read} !== 2'b10) begin
      failures++;
      $display("FAIL size11 got mis=%b rd=%b required 1 0", bus.mem_misaligned, bus.mem_mem_read);
    end
    drive(1'b1, 32'h1001, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
    step();
    checks++;
    if ({bus.mem_misaligned, bus.mem_mem_write, bus.mem_reg_write} !== 3'b101) begin
      failures++;
      $display("FAIL sh_misaligned got mis=%b wr=%b rw=%b required 1 0 1",
               bus.mem_misaligned, bus.mem_mem_write, bus.mem_reg_write);
    end
    drive(1'b0, 32'h1001, 32'h0, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    step();
    checks++;
    if ({bus.mem_valid, bus.mem_misaligned, bus.mem_mem_read, bus.mem_reg_write} !== 4'b0000) begin
      failures++;
      $display("FAIL invalid_slot got v=%b mis=%b rd=%b rw=%b required 0 0 0 0",
               bus.mem_valid, bus.mem_misaligned, bus.mem_mem_read, bus.mem_reg_write);
    end
    drive(1'b1, 32'h2000, 32'h0, 32'h5, 5'd8, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0);
    step();
    checks++;
    if ({bus.mem_mem_read, bus.mem_mem_write, bus.forward_ex_mem_en} !== 3'b011) begin
      failures++;
      $display("FAIL rd_and_wr got rd=%b wr=%b en=%b required 0 1 1",
               bus.mem_mem_read, bus.mem_mem_write, bus.forward_ex_mem_en);
    end
  endtask

  task automatic test_x0_load();
    drive(1'b1, 32'h77, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    step();
    checks++;
    if ({bus.forward_ex_mem_en, bus.mem_reg_write, bus.mem_valid} !== 3'b001) begin
      failures++;
      $display("FAIL add_x0 got en=%b rw=%b v=%b required 0 0 1",
               bus.forward_ex_mem_en, bus.mem_reg_write, bus.mem_valid);
    end
    drive(1'b1, 32'h1000, 32'h0, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    step();
    checks++;
    if ({bus.mem_mem_read, bus.mem_reg_write, bus.forward_ex_mem_en, bus.forward_ex_mem_rd} !== {3'b110, 5'd7}) begin
      failures++;
      $display("FAIL lw_x7 got rd=%b rw=%b en=%b frd=%0d required 1 1 0 7",
               bus.mem_mem_read, bus.mem_reg_write, bus.forward_ex_mem_en, bus.forward_ex_mem_rd);
    end
  endtask

  task automatic test_link();
    logic [31:0] exp_a;
    logic [31:0] exp_b;
`ifdef EX_MEM_LINK_FWD_EN
    exp_a = 32'h84;
    exp_b = 32'h0;
`else
    exp_a = 32'h200;
    exp_b = 32'h200;
`endif
    drive(1'b1, 32'h200, 32'h80, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1);
    step();
    checks++;
    if ({bus.forward_ex_mem, bus.mem_addr, bus.forward_ex_mem_en} !== {exp_a, 32'h200, 1'b1}) begin
      failures++;
      $display("FAIL jal_fwd got fwd=%h addr=%h en=%b required %h 00000200 1",
               bus.forward_ex_mem, bus.mem_addr, bus.forward_ex_mem_en, exp_a);
    end
    drive(1'b1, 32'h200, 32'hFFFF_FFFC, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1);
    step();
    checks++;
    if (bus.forward_ex_mem !== exp_b) begin
      failures++;
      $display("FAIL jal_wrap got=%h required=%h", bus.forward_ex_mem, exp_b);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h3000 + 32'(i * 16), 32'h0, 32'(i), 5'(10 + i), 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
      step();
      checks++;
      if ({bus.forward_ex_mem, bus.forward_ex_mem_rd, bus.mem_store_data, bus.forward_ex_mem_en}
          !== {32'h3000 + 32'(i * 16), 5'(10 + i), 32'(i), 1'b1}) begin
        failures++;
        $display("FAIL b2b_%0d got fwd=%h rd=%0d sd=%h en=%b", i, bus.forward_ex_mem,
                 bus.forward_ex_mem_rd, bus.mem_store_data, bus.forward_ex_mem_en);
      end
    end
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    test_reset();
    test_stall_flush();
    test_alignment();
    test_x0_load();
    test_link();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
